// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Contents:
//   uart_state_t     - frame FSM state encoding (IDLE, START, DATA, STOP)
//   OVERSAMPLE_DEF   - default clk cycles per bit period
//   STOP_BITS_DEF    - default number of stop bits
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int STOP_BITS_DEF  = 1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - sampling clock
//   rst  - synchronous active-high reset; both flops take RST_VAL
//   d    - asynchronous input
//   q    - synchronized output, two cycles behind d
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {2{RST_VAL}};
        end else begin
            ff <= {ff[0], d};
        end
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, no parity, LSB first, STOP_BITS stop bits.
// The line is oversampled OVERSAMPLE times per bit; each bit is sampled at
// its centre, located by re-checking the start bit half a bit period in.
// Ports:
//   clk          - clock
//   rst          - synchronous active-high reset
//   rx           - serial line, idle high, asynchronous to clk
//   data         - received byte, stable while valid is high
//   valid        - data holds an unconsumed byte
//   ready        - consumer accepts data when valid && ready
//   framing_err  - one-cycle pulse when a stop-bit sample was 0
//   overrun      - one-cycle pulse when a good byte was dropped
//   busy         - high whenever a frame is in progress
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int STOP_BITS  = STOP_BITS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    logic rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    uart_state_t   state, state_next;
    logic [TW-1:0] tick, tick_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [7:0]    shift, shift_next;
    logic          bad, bad_next;
    logic          frame_done;
    logic          frame_good;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            bad     <= 1'b0;
        end else begin
            state   <= state_next;
            tick    <= tick_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            bad     <= bad_next;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick;
        bit_next   = bit_cnt;
        shift_next = shift;
        bad_next   = bad;
        frame_done = 1'b0;
        frame_good = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_next = ST_START;
                    tick_next  = '0;
                end
            end
            ST_START: begin
                if (tick == TICK_MID) begin
                    // A line already back high at mid-bit was a glitch.
                    state_next = rx_s ? ST_IDLE : ST_DATA;
                    tick_next  = '0;
                    bit_next   = '0;
                    bad_next   = 1'b0;
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            ST_DATA: begin
                if (tick == TICK_LAST) begin
                    tick_next  = '0;
                    shift_next = {rx_s, shift[7:1]};
                    bit_next   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            ST_STOP: begin
                if (tick == TICK_LAST) begin
                    tick_next = '0;
                    if (!rx_s) begin
                        bad_next = 1'b1;
                    end
                    if (bit_cnt == STOP_LAST) begin
                        // Leave on the sample itself so a following start
                        // bit with no idle gap is still caught.
                        frame_done = 1'b1;
                        frame_good = !bad && rx_s;
                        state_next = ST_IDLE;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_cnt + 3'd1;
                    end
                end else begin
                    tick_next = tick + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= 8'h00;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_done && !frame_good;
            overrun     <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (frame_done && frame_good) begin
                // A handshake on the same cycle frees the buffer for the new byte.
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    localparam int OS = 16;
    localparam int SB = 1;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         valid_rise_cyc = -1;
    logic       valid_d = 1'b0;
    bit         held = 1'b0;
    logic [7:0] held_b = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic void push_ev(input ev_kind_t k, input logic [7:0] b);
        ev_t e;
        e.kind = k;
        e.b    = b;
        exp_q.push_back(e);
    endfunction

    // Reference model: what one received frame should produce, given the
    // consumer is either always accepting or holding off completely.
    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            push_ev(EV_FERR, 8'h00);
        end else if (ready) begin
            push_ev(EV_DATA, b);
        end else if (!held) begin
            held   = 1'b1;
            held_b = b;
        end else begin
            push_ev(EV_OVR, 8'h00);
        end
    endfunction

    task automatic pop_cmp(input ev_kind_t k, input logic [7:0] b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual_kind=%0d required=none", k);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", k, e.kind);
            if (k == EV_DATA && e.kind == EV_DATA) begin
                check("rx_byte", b, e.b);
            end
        end
    endtask

    always @(negedge clk) begin
        valid_d <= valid;
        if (valid && !valid_d) valid_rise_cyc <= cyc;
        if (!rst) begin
            if (valid && ready) pop_cmp(EV_DATA, data);
            if (framing_err)    pop_cmp(EV_FERR, 8'h00);
            if (overrun)        pop_cmp(EV_OVR, 8'h00);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cycles(OS);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        for (int i = 1; i < SB; i++) drive_bit(1'b1);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"drain_", name}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lat;
        int lat;
        int busy_cnt;
        int n;
        logic [7:0] str [4];
        logic [7:0] b;
        bit ok;

        rx    = 1'b1;
        ready = 1'b1;
        rst   = 1'b1;
        cycles(4);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {framing_err, overrun}, 0);
        rst = 1'b0;
        cycles(5);

        // Single frame, accepting consumer, plus end-to-end latency.
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1);
        wait_drain(400, "a5");
        exp_lat = 2 + ((19 + 2 * (SB - 1)) * OS) / 2;
        lat = valid_rise_cyc - start_cyc;
        checks++;
        if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
            errors++;
            $display("FAIL latency actual=%0d required=%0d+-1", lat, exp_lat);
        end
        cycles(20);

        // Back-to-back frames with the consumer stalled: hold, then overrun.
        ready = 1'b0;
        model_frame(8'h00, 1'b1);
        model_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain(100, "overrun");
        check("held_valid", valid, 1);
        check("held_data", data, held_b);
        push_ev(EV_DATA, held_b);
        held  = 1'b0;
        ready = 1'b1;
        wait_drain(20, "release");
        cycles(30);
        check("after_release_valid", valid, 0);

        // Bad stop bit.
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0);
        wait_drain(100, "ferr");
        cycles(2 * OS);
        check("ferr_valid", valid, 0);

        // Short low glitch on the line.
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) rx = 1'b1;
            cycles(1);
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt > 8) begin
            errors++;
            $display("FAIL glitch_busy actual=%0d required<=8", busy_cnt);
        end
        check("glitch_busy_end", busy, 0);
        check("glitch_valid", valid, 0);

        // Reset during data bit 4 of a frame, then a clean frame.
        b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        cycles(OS / 2);
        rst = 1'b1;
        cycles(3);
        check("abort_busy", busy, 0);
        check("abort_pulses", {framing_err, overrun, valid}, 0);
        rx  = 1'b1;
        rst = 1'b0;
        cycles(10);
        model_frame(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1);
        wait_drain(100, "after_abort");
        cycles(10);

        // Line stuck low: a framing error every frame, never valid.
        for (int i = 0; i < 3; i++) push_ev(EV_FERR, 8'h00);
        rx = 1'b0;
        wait_drain(3 * 11 * OS + 200, "stuck_low");
        rx = 1'b1;
        cycles(3 * OS);
        check("stuck_low_valid", valid, 0);
        check("stuck_low_busy", busy, 0);

        // Loopback-style string with no idle gap between frames.
        str[0] = 8'h30; str[1] = 8'h78; str[2] = 8'h31; str[3] = 8'h46;
        for (int i = 0; i < 4; i++) model_frame(str[i], 1'b1);
        for (int i = 0; i < 4; i++) send_frame(str[i], 1'b1);
        wait_drain(100, "string");
        cycles(10);

        // Randomized frames, occasional bad stop bit, random idle gaps.
        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 7) != 0);
            model_frame(b, ok);
            send_frame(b, ok);
            n = $urandom_range(0, 12);
            if (!ok) n = n + 2 * OS;
            if (n > 0) cycles(n);
        end
        wait_drain(400, "random");
        cycles(20);
        check("final_valid", valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, clk cycles per bit period; legal range 4..64.
REQ-002 Parameter: STOP_BITS, 1, stop bit periods checked; legal values 1..2.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: rx  input  1  serial line; idle high, asynchronous to clk; frame is 8N1 LSB-first.
REQ-006 Port: data  output  8  received byte; stable while valid=1.
REQ-007 Port: valid  output  1  data holds an unconsumed byte.
REQ-008 Port: ready  input  1  consumer accepts data; transfer occurs on a cycle with valid=1 and ready=1.
REQ-009 Port: framing_err  output  1  one-cycle pulse when a stop-bit sample is 0.
REQ-010 Port: overrun  output  1  one-cycle pulse when a completed byte is dropped because valid was still 1.
REQ-011 Port: busy  output  1  high in every state other than IDLE.

Function
REQ-012 rx passes through a 2-flop synchronizer; all logic below uses the synchronized value rx_s, which adds 2 cycles of latency.
REQ-013 FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: a cycle with rx_s=0 moves to START and loads the tick counter with 0.
REQ-015 START: at tick OVERSAMPLE/2-1 (mid-bit), rx_s=1 returns to IDLE as a glitch with no output; rx_s=0 moves to DATA with the tick counter cleared.
REQ-016 DATA: rx_s is sampled every OVERSAMPLE ticks; the sample shifts into bit[7] of the shift register (right shift). After the 8th sample the FSM moves to STOP.
REQ-017 STOP: STOP_BITS samples are taken, OVERSAMPLE ticks apart; any 0 sample marks the frame bad.
REQ-018 End of STOP, good frame with valid=0: data is loaded, and valid rises on the next cycle.
REQ-019 End of STOP, good frame with valid=1 and no handshake on that cycle: the new byte is discarded, data is unchanged, and overrun pulses.
REQ-020 End of STOP with a simultaneous handshake (valid=1, ready=1): the handshake completes, the new byte loads, and valid stays 1 with no overrun.
REQ-021 Bad frame: the byte is discarded, framing_err pulses, and valid and data are unchanged.
REQ-022 After STOP the FSM returns to IDLE on the same cycle as the last sample, so back-to-back frames with no idle gap are received.
REQ-023 A handshake clears valid on the next cycle unless REQ-020 applies.
REQ-024 The tick counter is $clog2(OVERSAMPLE) bits wide and wraps to 0 at OVERSAMPLE-1. The bit counter is 3 bits wide and wraps from 7 to 0.
REQ-025 End-to-end latency: valid rises 2 cycles (sync) + (9.5+STOP_BITS-1)*OVERSAMPLE cycles ±1 after the start edge on rx.
REQ-026 rx held low continuously produces a framing_err every frame and never asserts valid.

Reset
REQ-027 While rst=1: state=IDLE, valid=0, data=8'h00, framing_err=0, overrun=0, busy=0, all counters at 0, and synchronizer flops at 1.
REQ-028 Reset asserted mid-frame aborts the frame with no pulse outputs. The first start bit is recognised no earlier than 3 cycles after rst deasserts.

Structure
REQ-029 Shared package uart_pkg holds the FSM state encoding constants (IDLE, START, DATA, STOP) and the default OVERSAMPLE and STOP_BITS values; the uart_tx family uses the same package.
REQ-030 One sub-module, uart_sync2: a 2-flop synchronizer with a reset value parameter. All other logic stays in uart_rx.

Verification
REQ-031 With OVERSAMPLE=16, frame 8'hA5 driven with ready=1 -> valid pulses once, data=8'hA5, no error pulses.
REQ-032 Two back-to-back frames 8'h00 then 8'hFF with ready=0 -> the first is held with data=8'h00, the second is dropped with one overrun pulse. Then ready=1 -> exactly one transfer.
REQ-033 Frame 8'h3C with its stop bit forced to 0 -> one framing_err pulse, valid stays 0.
REQ-034 rx low pulse of 4 cycles, shorter than OVERSAMPLE/2 -> FSM returns to IDLE, no valid, no error; busy high for at most 8 cycles.
REQ-035 rst asserted at data bit 4 of a frame, released, then frame 8'h5A sent -> only 8'h5A is received, with no pulses from the aborted frame.
REQ-036 Loopback from uart_tx, OVERSAMPLE=1 equivalent clock ratio 16, sending the string "0x1F" -> bytes 0x30, 0x78, 0x31, 0x46 received in order.
